// File: rtl/ula.sv
// ULA: 8-bit add/subtract unit of the nRisc datapath.
// Result is registered; Zero is decoded from the registered result.
module ula (
    input  logic [7:0] bReg,
    input  logic [7:0] mux,
    output logic       Zero,
    output logic [7:0] out,
    input  logic       OpULA,
    input  logic       clock,
    input  logic       reset
);

    logic [7:0] operand_b;
    logic [7:0] carry_in;
    logic [7:0] out_d;
    logic [7:0] out_q;

    // Subtract is done as bReg + ~mux + 1; the final carry/borrow is dropped.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        operand_b = mux;
        carry_in  = 8'h00;
        if (OpULA == 1'b1) begin
            operand_b = ~mux;
            carry_in  = 8'h01;
        end
        out_d = bReg + operand_b + carry_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q <= 8'h00;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            out_q <= out_d;
        end
    end

    assign out  = out_q;
    assign Zero = (out_q == 8'h00);

endmodule

// File: tb/tb_ula.sv
// Scoreboard bench for ula: stimulus pushes expected results, a monitor
// pops and compares one edge later.
module tb_ula;

    logic       clock;
    logic       reset;
    logic [7:0] bReg;
    logic [7:0] mux;
    logic       OpULA;
    logic       Zero;
    logic [7:0] out;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    ula dut (
        .bReg (bReg),
        .mux  (mux),
        .Zero (Zero),
        .out  (out),
        .OpULA(OpULA),
        .clock(clock),
        .reset(reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: plain integer arithmetic reduced modulo 256.
    function automatic logic [7:0] model(input logic [7:0] b, input logic [7:0] m, input logic op);
        int r;
        if (op) r = int'(b) - int'(m);
        else    r = int'(b) + int'(m);
        r = ((r % 256) + 256) % 256;
        return r[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply(input logic [7:0] b, input logic [7:0] m, input logic op);
        @(negedge clock);
        bReg  = b;
        mux   = m;
        OpULA = op;
        exp_q.push_back(model(b, m, op));
    endtask

    // Monitor: compare each queued expectation just after the capturing edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out", {24'h0, out}, {24'h0, e});
                check("zero", {31'h0, Zero}, {31'h0, (e == 8'h00)});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        reset = 1'b1;
        bReg  = 8'($urandom);
        mux   = 8'($urandom);
        OpULA = 1'b0;

        repeat (3) @(negedge clock);
        check("reset_out", {24'h0, out}, 32'h0);
        check("reset_zero", {31'h0, Zero}, 32'h1);
        reset = 1'b0;

        // Directed add / subtract / wrap-around vectors
        apply(8'h01, 8'h01, 1'b0);
        apply(8'h00, 8'h00, 1'b0);
        apply(8'h01, 8'h01, 1'b0);
        apply(8'h01, 8'd11, 1'b0);
        apply(8'h01, 8'd11, 1'b1);
        apply(8'd10, 8'd11, 1'b1);
        apply(8'd11, 8'd11, 1'b1);
        apply(8'hFF, 8'h01, 1'b0);
        apply(8'h80, 8'h80, 1'b0);
        apply(8'h00, 8'hFF, 1'b1);
        apply(8'h00, 8'h01, 1'b1);

        // Mid-cycle operand change, then asynchronous reset pulse
        apply(8'h01, 8'd11, 1'b0);
        @(posedge clock);
        #2;
        bReg  = 8'hA5;
        mux   = 8'h3C;
        OpULA = 1'b1;
        #1;
        check("hold_between_edges", {24'h0, out}, 32'h0C);
        reset = 1'b1;
        #1;
        check("async_reset_out", {24'h0, out}, 32'h0);
        check("async_reset_zero", {31'h0, Zero}, 32'h1);
        @(posedge clock);
        #1;
        check("reset_held_out", {24'h0, out}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("after_release_out", {24'h0, out}, 32'h0);

        // Randomized vectors, with a bias toward equal operands
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] b;
            logic [7:0] m;
            b = 8'($urandom);
            m = ($urandom_range(0, 7) == 0) ? b : 8'($urandom);
            apply(b, m, 1'($urandom));
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(posedge clock);
            guard++;
        end
        #2;
        check("scoreboard_drained", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
